// File: rtl/traffic_ctrl_n.sv
// N-phase traffic-light controller: green/yellow/all-red sequencing, maintenance flash,
// internal 1 Hz tick enable. Optional latched pedestrian requests under `TRAFFIC_PED_EN.
module traffic_ctrl_n #(
    parameter int FPGA_FREQ    = 50_000_000,
    parameter int NUM_PHASES   = 2,
    parameter int T_GREEN_MAIN = 8,
    parameter int T_GREEN_SEC  = 6,
    parameter int T_YELLOW     = 2,
    parameter int T_ALLRED     = 1,
    parameter int T_PED_EXT    = 4,
    parameter int CNT_W        = 4,
    localparam int PH_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flash_req,
    input  logic [NUM_PHASES-1:0]   ped_req,
    output logic [3*NUM_PHASES-1:0] lights,
    output logic [NUM_PHASES-1:0]   walk,
    output logic [PH_W-1:0]         phase,
    output logic                    tick
);

    localparam int DIV_W = (FPGA_FREQ > 1) ? $clog2(FPGA_FREQ) : 1;

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2,
        S_FLASH  = 2'd3
    } state_t;

    logic [DIV_W-1:0]        div_q, div_d;
    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [CNT_W-1:0]        sec_q, sec_d;
    logic                    flash_on_q, flash_on_d;
    logic                    ped_ext_q, ped_ext_d;
    logic [NUM_PHASES-1:0]   walk_q, walk_d;
    logic [NUM_PHASES-1:0]   pend_q, pend_d;
    logic [NUM_PHASES-1:0]   pend_clr;
    logic [3*NUM_PHASES-1:0] lights_q, lights_d;
    logic [PH_W-1:0]         next_phase;
    logic [CNT_W-1:0]        green_len;

    function automatic logic [3*NUM_PHASES-1:0] decode(input state_t s,
                                                       input logic [PH_W-1:0] p,
                                                       input logic f);
        logic [3*NUM_PHASES-1:0] l;
        for (int i = 0; i < NUM_PHASES; i++) begin
            l[3*i +: 3] = 3'b100;
            if (s == S_FLASH)
                l[3*i +: 3] = f ? 3'b010 : 3'b000;
            else if (p == PH_W'(i) && s == S_GREEN)
                l[3*i +: 3] = 3'b001;
            else if (p == PH_W'(i) && s == S_YELLOW)
                l[3*i +: 3] = 3'b010;
        end
        return l;
    endfunction

    assign tick = (div_q == DIV_W'(FPGA_FREQ - 1));

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        div_d      = tick ? '0 : div_q + 1'b1;
        state_d    = state_q;
        phase_d    = phase_q;
        sec_d      = sec_q;
        flash_on_d = flash_on_q;
        ped_ext_d  = ped_ext_q;
        walk_d     = walk_q;
        pend_clr   = '0;
        next_phase = (phase_q == PH_W'(NUM_PHASES - 1)) ? '0 : phase_q + 1'b1;
        green_len  = (phase_q == '0) ? CNT_W'(T_GREEN_MAIN) : CNT_W'(T_GREEN_SEC);
        if (ped_ext_q)
            green_len = green_len + CNT_W'(T_PED_EXT);

        if (tick) begin
            sec_d = sec_q + 1'b1;
            if (flash_req && state_q != S_FLASH) begin
                state_d    = S_FLASH;
                sec_d      = '0;
                flash_on_d = 1'b1;
                ped_ext_d  = 1'b0;
                walk_d     = '0;
            end else begin
                case (state_q)
                    S_GREEN: if (sec_q == green_len - 1'b1) begin
                        state_d   = S_YELLOW;
                        sec_d     = '0;
                        ped_ext_d = 1'b0;
                        walk_d    = '0;
                    end
                    S_YELLOW: if (sec_q == CNT_W'(T_YELLOW - 1)) begin
                        state_d = S_ALLRED;
                        sec_d   = '0;
                    end
                    S_ALLRED: if (sec_q == CNT_W'(T_ALLRED - 1)) begin
                        state_d = S_GREEN;
                        sec_d   = '0;
                        phase_d = next_phase;
                        // Only a request latched before this edge earns the extension.
                        if (pend_q[next_phase]) begin
                            pend_clr[next_phase] = 1'b1;
                            walk_d[next_phase]   = 1'b1;
                            ped_ext_d            = 1'b1;
                        end
                    end
                    default: if (!flash_req) begin
                        state_d    = S_ALLRED;
                        sec_d      = '0;
                        phase_d    = PH_W'(NUM_PHASES - 1);
                        flash_on_d = 1'b0;
                    end else begin
                        flash_on_d = ~flash_on_q;
                    end
                endcase
            end
        end

`ifdef TRAFFIC_PED_EN
        pend_d = (pend_q & ~pend_clr) | ped_req;
`else
        pend_d = '0;
`endif
        lights_d = decode(state_d, phase_d, flash_on_d);
    end

`ifndef TRAFFIC_PED_EN
    logic unused_ped;
    assign unused_ped = ^ped_req;
`endif

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            state_q    <= S_GREEN;
            phase_q    <= '0;
            sec_q      <= '0;
            flash_on_q <= 1'b0;
            ped_ext_q  <= 1'b0;
            walk_q     <= '0;
            pend_q     <= '0;
            lights_q   <= decode(S_GREEN, '0, 1'b0);
        end else begin
            div_q      <= div_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            sec_q      <= sec_d;
            flash_on_q <= flash_on_d;
            ped_ext_q  <= ped_ext_d;
            walk_q     <= walk_d;
            pend_q     <= pend_d;
            lights_q   <= lights_d;
        end
    end

    assign lights = lights_q;
    assign walk   = walk_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Self-checking bench for traffic_ctrl_n: directed vector table plus randomized run
// against a countdown-based reference model of the light schedule.
module tb_traffic_ctrl_n;

    localparam int F   = 4;
    localparam int N   = 3;
    localparam int TGM = 3;
    localparam int TGS = 2;
    localparam int TY  = 1;
    localparam int TAR = 1;
    localparam int TPE = 2;
`ifdef TRAFFIC_PED_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           flash_req;
    logic [N-1:0]   ped_req;
    logic [3*N-1:0] lights;
    logic [N-1:0]   walk;
    logic [1:0]     phase;
    logic           tick;

    traffic_ctrl_n #(
        .FPGA_FREQ(F), .NUM_PHASES(N), .T_GREEN_MAIN(TGM), .T_GREEN_SEC(TGS),
        .T_YELLOW(TY), .T_ALLRED(TAR), .T_PED_EXT(TPE), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .flash_req(flash_req), .ped_req(ped_req),
        .lights(lights), .walk(walk), .phase(phase), .tick(tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int scen   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s scen=%0d cyc=%0d: got %h expected %h", name, scen, cyc, act, exp);
        end
    endtask

    // Reference model: each state holds a count of ticks still to run.
    typedef enum {M_GREEN, M_YELLOW, M_ALLRED, M_FLASH} mmode_t;
    mmode_t   m_mode;
    int       m_cnt, m_left, m_phase;
    bit       m_lit;
    bit [N-1:0] m_walk, m_pend;

    function automatic int green_ticks(input int p, input bit ped);
        return ((p == 0) ? TGM : TGS) + (ped ? TPE : 0);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_mode = M_GREEN; m_phase = 0; m_left = green_ticks(0, 1'b0);
        m_lit = 1'b0; m_walk = '0; m_pend = '0;
    endtask

    task automatic model_step(input bit r, input bit fr, input bit [N-1:0] pr);
        int  np;
        bit  served;
        if (r) begin
            model_reset();
            return;
        end
        if (m_cnt % F == F - 1) begin
            if (fr && m_mode != M_FLASH) begin
                m_mode = M_FLASH; m_lit = 1'b1; m_walk = '0;
            end else begin
                case (m_mode)
                    M_GREEN: begin
                        m_left--;
                        if (m_left == 0) begin m_mode = M_YELLOW; m_left = TY; m_walk = '0; end
                    end
                    M_YELLOW: begin
                        m_left--;
                        if (m_left == 0) begin m_mode = M_ALLRED; m_left = TAR; end
                    end
                    M_ALLRED: begin
                        m_left--;
                        if (m_left == 0) begin
                            np      = (m_phase + 1) % N;
                            served  = PED_EN && m_pend[np];
                            m_phase = np;
                            m_mode  = M_GREEN;
                            m_left  = green_ticks(np, served);
                            if (served) begin m_pend[np] = 1'b0; m_walk[np] = 1'b1; end
                        end
                    end
                    default: begin
                        if (!fr) begin m_mode = M_ALLRED; m_phase = N - 1; m_left = TAR; end
                        else m_lit = !m_lit;
                    end
                endcase
            end
        end
        if (PED_EN) m_pend = m_pend | pr;
        m_cnt++;
    endtask

    function automatic logic [3*N-1:0] exp_lights();
        logic [3*N-1:0] l;
        for (int i = 0; i < N; i++) begin
            if (m_mode == M_FLASH)                        l[3*i +: 3] = m_lit ? 3'b010 : 3'b000;
            else if (i == m_phase && m_mode == M_GREEN)   l[3*i +: 3] = 3'b001;
            else if (i == m_phase && m_mode == M_YELLOW)  l[3*i +: 3] = 3'b010;
            else                                          l[3*i +: 3] = 3'b100;
        end
        return l;
    endfunction

    typedef struct {
        int             scen;
        int             cyc;
        logic [3*N-1:0] lights;
        logic [N-1:0]   walk;
        logic [1:0]     phase;
        logic           tick;
    } vec_t;
    vec_t vecs[$];

    function automatic void add_vec(input int s, input int c, input logic [3*N-1:0] l,
                                    input logic [N-1:0] w, input logic [1:0] p, input logic t);
        vec_t v;
        v.scen = s; v.cyc = c; v.lights = l; v.walk = w; v.phase = p; v.tick = t;
        vecs.push_back(v);
    endfunction

    bit rnd_fr = 1'b0;

    task automatic get_stim(input int s, input int c, output bit r, output bit fr, output bit [N-1:0] pr);
        r = 1'b0; fr = 1'b0; pr = '0;
        case (s)
            2: begin if (c == 5 || c == 25) pr = 3'b010; end
            3: fr = (c >= 8 && c <= 26);
            4: fr = (c == 11);
            5: begin if (c == 5) pr = 3'b100; r = (c == 30); end
            6: begin
                if ($urandom_range(0, 149) == 0) rnd_fr = !rnd_fr;
                fr = rnd_fr;
                if ($urandom_range(0, 19) == 0) pr = 3'($urandom_range(1, 7));
                r = ($urandom_range(0, 699) == 0);
            end
            default: ;
        endcase
    endtask

    task automatic run_scenario(input int s, input int n);
        bit r, fr;
        bit [N-1:0] pr;
        scen = s;
        reset = 1'b1; flash_req = 1'b0; ped_req = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < n; c++) begin
            cyc = c;
            check("lights", 32'(lights), 32'(exp_lights()));
            check("walk",   32'(walk),   32'(m_walk));
            check("phase",  32'(phase),  32'(m_phase));
            check("tick",   32'(tick),   32'(m_cnt % F == F - 1));
            foreach (vecs[k]) begin
                if (vecs[k].scen == s && vecs[k].cyc == c) begin
                    check("vec_lights", 32'(lights), 32'(vecs[k].lights));
                    check("vec_walk",   32'(walk),   32'(vecs[k].walk));
                    check("vec_phase",  32'(phase),  32'(vecs[k].phase));
                    check("vec_tick",   32'(tick),   32'(vecs[k].tick));
                end
            end
            get_stim(s, c, r, fr, pr);
            reset = r; flash_req = fr; ped_req = pr;
            @(posedge clk);
            model_step(r, fr, pr);
            @(negedge clk);
        end
    endtask

    localparam logic [8:0] G0 = 9'b100_100_001, Y0 = 9'b100_100_010;
    localparam logic [8:0] G1 = 9'b100_001_100, Y1 = 9'b100_010_100;
    localparam logic [8:0] G2 = 9'b001_100_100, Y2 = 9'b010_100_100;
    localparam logic [8:0] AR = 9'b100_100_100, FL = 9'b010_010_010, DK = 9'b000_000_000;

    initial begin
        reset = 1'b1; flash_req = 1'b0; ped_req = '0;

        // Nominal cycle
        add_vec(1, 0,  G0, 3'b000, 2'd0, 1'b0);
        add_vec(1, 3,  G0, 3'b000, 2'd0, 1'b1);
        add_vec(1, 4,  G0, 3'b000, 2'd0, 1'b0);
        add_vec(1, 11, G0, 3'b000, 2'd0, 1'b1);
        add_vec(1, 12, Y0, 3'b000, 2'd0, 1'b0);
        add_vec(1, 15, Y0, 3'b000, 2'd0, 1'b1);
        add_vec(1, 16, AR, 3'b000, 2'd0, 1'b0);
        add_vec(1, 19, AR, 3'b000, 2'd0, 1'b1);
        add_vec(1, 20, G1, 3'b000, 2'd1, 1'b0);
        add_vec(1, 27, G1, 3'b000, 2'd1, 1'b1);
        add_vec(1, 28, Y1, 3'b000, 2'd1, 1'b0);
        add_vec(1, 36, G2, 3'b000, 2'd2, 1'b0);
        add_vec(1, 43, G2, 3'b000, 2'd2, 1'b1);
        add_vec(1, 44, Y2, 3'b000, 2'd2, 1'b0);
        add_vec(1, 52, G0, 3'b000, 2'd0, 1'b0);
        // Pedestrian latch
`ifdef TRAFFIC_PED_EN
        add_vec(2, 20, G1, 3'b010, 2'd1, 1'b0);
        add_vec(2, 28, G1, 3'b010, 2'd1, 1'b0);
        add_vec(2, 35, G1, 3'b010, 2'd1, 1'b1);
        add_vec(2, 36, Y1, 3'b000, 2'd1, 1'b0);
        add_vec(2, 44, G2, 3'b000, 2'd2, 1'b0);
        add_vec(2, 80, G1, 3'b010, 2'd1, 1'b0);
        add_vec(2, 95, G1, 3'b010, 2'd1, 1'b1);
        add_vec(2, 96, Y1, 3'b000, 2'd1, 1'b0);
`else
        add_vec(2, 20, G1, 3'b000, 2'd1, 1'b0);
        add_vec(2, 27, G1, 3'b000, 2'd1, 1'b1);
        add_vec(2, 28, Y1, 3'b000, 2'd1, 1'b0);
`endif
        // Flash entry/exit
        add_vec(3, 11, G0, 3'b000, 2'd0, 1'b1);
        add_vec(3, 12, FL, 3'b000, 2'd0, 1'b0);
        add_vec(3, 15, FL, 3'b000, 2'd0, 1'b1);
        add_vec(3, 16, DK, 3'b000, 2'd0, 1'b0);
        add_vec(3, 19, DK, 3'b000, 2'd0, 1'b1);
        add_vec(3, 20, FL, 3'b000, 2'd0, 1'b0);
        add_vec(3, 24, DK, 3'b000, 2'd0, 1'b0);
        add_vec(3, 28, AR, 3'b000, 2'd2, 1'b0);
        add_vec(3, 31, AR, 3'b000, 2'd2, 1'b1);
        add_vec(3, 32, G0, 3'b000, 2'd0, 1'b0);
        // Flash wins over simultaneous green expiry
        add_vec(4, 12, FL, 3'b000, 2'd0, 1'b0);
        add_vec(4, 16, AR, 3'b000, 2'd2, 1'b0);
        add_vec(4, 20, G0, 3'b000, 2'd0, 1'b0);
        // Mid-operation reset with a pending request
        add_vec(5, 30, Y1, 3'b000, 2'd1, 1'b0);
        add_vec(5, 31, G0, 3'b000, 2'd0, 1'b0);
        add_vec(5, 33, G0, 3'b000, 2'd0, 1'b0);
        add_vec(5, 34, G0, 3'b000, 2'd0, 1'b1);
        add_vec(5, 67, G2, 3'b000, 2'd2, 1'b0);
        add_vec(5, 74, G2, 3'b000, 2'd2, 1'b1);
        add_vec(5, 75, Y2, 3'b000, 2'd2, 1'b0);

        run_scenario(1, 60);
        run_scenario(2, 100);
        run_scenario(3, 40);
        run_scenario(4, 30);
        run_scenario(5, 90);
        run_scenario(6, 3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
